mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single cache-line memory port between the instruction-fetch requester (ic_*)
//  and the data load/store requester (dc_*), one transaction outstanding at a time.
//  - Sits between the CPU fetch/LSU paths and mem.
//  - Priority: data first, with a starvation guard for fetch.
//  - Latches each granted request and holds it on the memory port until the response.
//  - Routes the response back by arbiter state.
// PARAMETERS
//  PADDR_WIDTH   20   physical address width
//  LINE_W        128  cache line width in bits (CACHE_LINE_BYTES*8)
//  SIZE_W        2    access-size encoding width
//  INSTR_SIZE    2'd3 access size driven for instruction fetches (full line)
//  STARVE_LIMIT  4    consecutive fetch losses before fetch is forced to win (>=1)
// PORTS
//  clk                clk  in   1            clock
//  rst                rst  in   1            synchronous, active-low reset
//  ic_req_valid_i          in   1            fetch request pending
//  ic_req_ready_o          out  1            fetch request accepted this cycle (combinational)
//  ic_addr_i               in   PADDR_WIDTH  fetch line address
//  ic_data_valid_o         out  1            1-cycle pulse, fetch line returned
//  ic_data_o               out  LINE_W       fetch line data
//  dc_req_valid_i          in   1            data request pending
//  dc_req_we_i             in   1            1 = write, 0 = read
//  dc_req_ready_o          out  1            data request accepted this cycle (combinational)
//  dc_addr_i               in   PADDR_WIDTH  data address
//  dc_wr_data_i            in   LINE_W       write data
//  dc_size_i               in   SIZE_W       access size
//  dc_data_valid_o         out  1            1-cycle pulse, read data returned
//  dc_data_o               out  LINE_W       read data
//  dc_wr_done_o            out  1            1-cycle pulse, write completed
//  mem_rd_req_valid_o      out  1            memory read request (level)
//  mem_wr_req_valid_o      out  1            memory write request (level)
//  mem_req_is_instr_o      out  1            request belongs to fetch
//  mem_req_address_o       out  PADDR_WIDTH  latched address
//  mem_wr_data_o           out  LINE_W       latched write data
//  mem_req_access_size_o   out  SIZE_W       latched size
//  mem_data_valid_i        in   1            memory read response
//  mem_data_is_instr_i     in   1            response tag
//  mem_data_i              in   LINE_W       response data
//  mem_write_done_i        in   1            memory write completion
//  err_o                   out  1            sticky protocol error
// BEHAVIOUR
//  States: IDLE, RD_I, RD_D, WR_D. Only IDLE accepts requests.
//  Handshake: valid/ready; a request is accepted on the cycle where valid&ready=1.
//    Requester holds valid and its fields stable until ready.
//    At most one ready is high per cycle, and only in IDLE.
//  Arbitration in IDLE:
//    - dc wins if dc valid, unless starve_cnt==STARVE_LIMIT and ic valid, then ic wins.
//    - ic wins when alone.
//  starve_cnt: +1 (saturating at STARVE_LIMIT) when ic valid loses; 0 on ic grant or when ic valid=0.
//  Accept at edge N:
//    - Latch addr, data, size and is_instr.
//    - Go to RD_I (ic), RD_D (dc & !we) or WR_D (dc & we).
//    - mem_*_req_valid_o high from cycle N+1; held until the response cycle inclusive.
//  Response, with ic/dc data outputs registered (1-cycle latency):
//    - mem_data_valid_i in RD_I/RD_D: capture mem_data_i; pulse ic_/dc_data_valid_o next cycle; state->IDLE.
//    - mem_write_done_i in WR_D: pulse dc_wr_done_o next cycle; state->IDLE.
//    - In IDLE, data_valid_o/wr_done_o may pulse while a new request is accepted (back-to-back allowed).
//    - Minimum request-to-request spacing on the memory port: 1 idle cycle.
//  Errors (err_o set and sticky until reset; state still advances as normal):
//    - mem_data_is_instr_i disagrees with the state on a response.
//    - Any response while IDLE is dropped and sets err_o.
//    - mem_data_valid_i in WR_D, or mem_write_done_i in RD_*, is ignored and sets err_o.
//  Reset (rst==0 at a clock edge), including mid-transaction:
//    - state=IDLE, starve_cnt=0.
//    - All valid/done/req outputs=0, err_o=0.
//    - Latched addr/data/size=0, data outputs=0.
//    - The in-flight transaction is abandoned.
//  ready outputs are 0 while rst==0.
// TESTING
//  1. Reset with both valids high -> no ready and all mem outputs 0 during reset. First IDLE cycle
//     after reset: dc_req_ready_o=1.
//  2. ic read 0x1000 alone; mem returns 0xAB.. after 3 cycles -> mem_rd_req_valid_o=1 with
//     is_instr=1 and size=INSTR_SIZE. ic_data_valid_o pulses 1 cycle with 0xAB.., one cycle after
//     the response.
//  3. dc write 0x1FF0 (size 2) with ic valid held -> WR_D first. After write_done, ic granted.
//     dc_wr_done_o is a single pulse.
//  4. dc valid held continuously plus ic valid -> dc wins 4 times, ic wins the 5th grant, and
//     starve_cnt returns to 0.
//  5. Response with mem_data_is_instr_i=1 during RD_D, and mem_write_done_i in IDLE -> err_o=1
//     and stays 1 until reset. dc data still delivered.
//  6. rst low 2 cycles during RD_D, then a late mem_data_valid_i -> no dc_data_valid_o, err_o=1.
//     A new request proceeds normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one cache-line memory port between the fetch (ic) and data (dc) requesters.
// One transaction outstanding; data has priority with a starvation guard for fetch.
module mem_port_arbiter #(
  parameter int unsigned       PADDR_WIDTH  = 20,
  parameter int unsigned       LINE_W       = 128,
  parameter int unsigned       SIZE_W       = 2,
  parameter logic [SIZE_W-1:0] INSTR_SIZE   = SIZE_W'(3),
  parameter int unsigned       STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   ic_req_valid_i,
  output logic                   ic_req_ready_o,
  input  logic [PADDR_WIDTH-1:0] ic_addr_i,
  output logic                   ic_data_valid_o,
  output logic [LINE_W-1:0]      ic_data_o,

  input  logic                   dc_req_valid_i,
  input  logic                   dc_req_we_i,
  output logic                   dc_req_ready_o,
  input  logic [PADDR_WIDTH-1:0] dc_addr_i,
  input  logic [LINE_W-1:0]      dc_wr_data_i,
  input  logic [SIZE_W-1:0]      dc_size_i,
  output logic                   dc_data_valid_o,
  output logic [LINE_W-1:0]      dc_data_o,
  output logic                   dc_wr_done_o,

  output logic                   mem_rd_req_valid_o,
  output logic                   mem_wr_req_valid_o,
  output logic                   mem_req_is_instr_o,
  output logic [PADDR_WIDTH-1:0] mem_req_address_o,
  output logic [LINE_W-1:0]      mem_wr_data_o,
  output logic [SIZE_W-1:0]      mem_req_access_size_o,
  input  logic                   mem_data_valid_i,
  input  logic                   mem_data_is_instr_i,
  input  logic [LINE_W-1:0]      mem_data_i,
  input  logic                   mem_write_done_i,

  output logic                   err_o
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_I = 2'd1,
    RD_D = 2'd2,
    WR_D = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             idle;
  logic             starved;
  logic             ic_grant;
  logic             dc_grant;

  // Grant decision: dc first, unless fetch has lost STARVE_LIMIT times in a row.
  always_comb begin
    idle     = rst && (state == IDLE);
    starved  = (starve_cnt == CNT_W'(STARVE_LIMIT));
    ic_grant = 1'b0;
    dc_grant = 1'b0;
    if (idle) begin
      if (ic_req_valid_i && (!dc_req_valid_i || starved)) begin
        ic_grant = 1'b1;
      end else if (dc_req_valid_i) begin
        dc_grant = 1'b1;
      end
    end
  end

  assign ic_req_ready_o = ic_grant;
  assign dc_req_ready_o = dc_grant;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state                 <= IDLE;
      starve_cnt            <= '0;
      ic_data_valid_o       <= 1'b0;
      ic_data_o             <= '0;
      dc_data_valid_o       <= 1'b0;
      dc_data_o             <= '0;
      dc_wr_done_o          <= 1'b0;
      mem_rd_req_valid_o    <= 1'b0;
      mem_wr_req_valid_o    <= 1'b0;
      mem_req_is_instr_o    <= 1'b0;
      mem_req_address_o     <= '0;
      mem_wr_data_o         <= '0;
      mem_req_access_size_o <= '0;
      err_o                 <= 1'b0;
    end else begin
      ic_data_valid_o <= 1'b0;
      dc_data_valid_o <= 1'b0;
      dc_wr_done_o    <= 1'b0;

      // A pending fetch only ages when it actually loses an arbitration.
      if (!ic_req_valid_i || ic_grant) begin
        starve_cnt <= '0;
      end else if (dc_grant && !starved) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (mem_data_valid_i || mem_write_done_i) begin
            err_o <= 1'b1;
          end
          if (ic_grant) begin
            state                 <= RD_I;
            mem_rd_req_valid_o    <= 1'b1;
            mem_req_is_instr_o    <= 1'b1;
            mem_req_address_o     <= ic_addr_i;
            mem_wr_data_o         <= '0;
            mem_req_access_size_o <= INSTR_SIZE;
          end else if (dc_grant) begin
            state                 <= dc_req_we_i ? WR_D : RD_D;
            mem_rd_req_valid_o    <= !dc_req_we_i;
            mem_wr_req_valid_o    <= dc_req_we_i;
            mem_req_is_instr_o    <= 1'b0;
            mem_req_address_o     <= dc_addr_i;
            mem_wr_data_o         <= dc_wr_data_i;
            mem_req_access_size_o <= dc_size_i;
          end
        end

        RD_I, RD_D: begin
          if (mem_write_done_i) begin
            err_o <= 1'b1;
          end
          if (mem_data_valid_i) begin
            // Routing follows the state; a mismatched tag is flagged but still delivered.
            if (mem_data_is_instr_i != (state == RD_I)) begin
              err_o <= 1'b1;
            end
            if (state == RD_I) begin
              ic_data_o       <= mem_data_i;
              ic_data_valid_o <= 1'b1;
            end else begin
              dc_data_o       <= mem_data_i;
              dc_data_valid_o <= 1'b1;
            end
            mem_rd_req_valid_o <= 1'b0;
            state              <= IDLE;
          end
        end

        WR_D: begin
          if (mem_data_valid_i) begin
            err_o <= 1'b1;
          end
          if (mem_write_done_i) begin
            dc_wr_done_o       <= 1'b1;
            mem_wr_req_valid_o <= 1'b0;
            state              <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

  localparam int unsigned PADDR_WIDTH = 20;
  localparam int unsigned LINE_W      = 128;
  localparam int unsigned SIZE_W      = 2;

  logic                   clk;
  logic                   rst;
  logic                   ic_req_valid;
  logic                   ic_req_ready;
  logic [PADDR_WIDTH-1:0] ic_addr;
  logic                   ic_data_valid;
  logic [LINE_W-1:0]      ic_data;
  logic                   dc_req_valid;
  logic                   dc_req_we;
  logic                   dc_req_ready;
  logic [PADDR_WIDTH-1:0] dc_addr;
  logic [LINE_W-1:0]      dc_wr_data;
  logic [SIZE_W-1:0]      dc_size;
  logic                   dc_data_valid;
  logic [LINE_W-1:0]      dc_data;
  logic                   dc_wr_done;
  logic                   mem_rd_req_valid;
  logic                   mem_wr_req_valid;
  logic                   mem_req_is_instr;
  logic [PADDR_WIDTH-1:0] mem_req_address;
  logic [LINE_W-1:0]      mem_wr_data;
  logic [SIZE_W-1:0]      mem_req_access_size;
  logic                   mem_data_valid;
  logic                   mem_data_is_instr;
  logic [LINE_W-1:0]      mem_data;
  logic                   mem_write_done;
  logic                   err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [LINE_W-1:0] line_ab;
  logic [LINE_W-1:0] line_55;
  logic [LINE_W-1:0] line_77;
  logic [LINE_W-1:0] line_wr;

  mem_port_arbiter dut (
    .clk                   (clk),
    .rst                   (rst),
    .ic_req_valid_i        (ic_req_valid),
    .ic_req_ready_o        (ic_req_ready),
    .ic_addr_i             (ic_addr),
    .ic_data_valid_o       (ic_data_valid),
    .ic_data_o             (ic_data),
    .dc_req_valid_i        (dc_req_valid),
    .dc_req_we_i           (dc_req_we),
    .dc_req_ready_o        (dc_req_ready),
    .dc_addr_i             (dc_addr),
    .dc_wr_data_i          (dc_wr_data),
    .dc_size_i             (dc_size),
    .dc_data_valid_o       (dc_data_valid),
    .dc_data_o             (dc_data),
    .dc_wr_done_o          (dc_wr_done),
    .mem_rd_req_valid_o    (mem_rd_req_valid),
    .mem_wr_req_valid_o    (mem_wr_req_valid),
    .mem_req_is_instr_o    (mem_req_is_instr),
    .mem_req_address_o     (mem_req_address),
    .mem_wr_data_o         (mem_wr_data),
    .mem_req_access_size_o (mem_req_access_size),
    .mem_data_valid_i      (mem_data_valid),
    .mem_data_is_instr_i   (mem_data_is_instr),
    .mem_data_i            (mem_data),
    .mem_write_done_i      (mem_write_done),
    .err_o                 (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    line_ab = {16{8'hAB}};
    line_55 = {16{8'h55}};
    line_77 = {16{8'h77}};
    line_wr = {8{16'hC0DE}};

    rst = 1'b0;
    ic_req_valid = 1'b1; ic_addr = 20'h00100;
    dc_req_valid = 1'b1; dc_req_we = 1'b0; dc_addr = 20'h00200;
    dc_wr_data = '0; dc_size = 2'd0;
    mem_data_valid = 1'b0; mem_data_is_instr = 1'b0; mem_data = '0; mem_write_done = 1'b0;

    // 1. reset with both requesters asserting
    tick(); tick();
    check("rst_ic_ready", 128'(ic_req_ready), 128'(0));
    check("rst_dc_ready", 128'(dc_req_ready), 128'(0));
    check("rst_mem_rd", 128'(mem_rd_req_valid), 128'(0));
    check("rst_mem_wr", 128'(mem_wr_req_valid), 128'(0));
    check("rst_addr", 128'(mem_req_address), 128'(0));
    check("rst_err", 128'(err), 128'(0));
    rst = 1'b1;
    #1;
    check("post_rst_dc_ready", 128'(dc_req_ready), 128'(1));
    check("post_rst_ic_ready", 128'(ic_req_ready), 128'(0));
    ic_req_valid = 1'b0;
    dc_req_valid = 1'b0;

    // 2. lone fetch
    tick();
    ic_req_valid = 1'b1; ic_addr = 20'h01000;
    #1;
    check("ic_alone_ready", 128'(ic_req_ready), 128'(1));
    tick();
    ic_req_valid = 1'b0;
    check("ic_rd_req", 128'(mem_rd_req_valid), 128'(1));
    check("ic_is_instr", 128'(mem_req_is_instr), 128'(1));
    check("ic_size", 128'(mem_req_access_size), 128'(3));
    check("ic_addr", 128'(mem_req_address), 128'(20'h01000));
    tick(); tick();
    mem_data_valid = 1'b1; mem_data_is_instr = 1'b1; mem_data = line_ab;
    #1;
    check("ic_rd_held_resp", 128'(mem_rd_req_valid), 128'(1));
    tick();
    mem_data_valid = 1'b0; mem_data_is_instr = 1'b0;
    check("ic_data_valid", 128'(ic_data_valid), 128'(1));
    check("ic_data", ic_data, line_ab);
    check("ic_rd_dropped", 128'(mem_rd_req_valid), 128'(0));
    tick();
    check("ic_data_valid_pulse", 128'(ic_data_valid), 128'(0));

    // 3. dc write beats a waiting fetch
    dc_req_valid = 1'b1; dc_req_we = 1'b1; dc_addr = 20'h01FF0; dc_size = 2'd2; dc_wr_data = line_wr;
    ic_req_valid = 1'b1; ic_addr = 20'h02000;
    #1;
    check("wr_dc_ready", 128'(dc_req_ready), 128'(1));
    check("wr_ic_ready", 128'(ic_req_ready), 128'(0));
    tick();
    dc_req_valid = 1'b0; dc_req_we = 1'b0;
    check("wr_req", 128'(mem_wr_req_valid), 128'(1));
    check("wr_rd_req", 128'(mem_rd_req_valid), 128'(0));
    check("wr_addr", 128'(mem_req_address), 128'(20'h01FF0));
    check("wr_data", mem_wr_data, line_wr);
    check("wr_size", 128'(mem_req_access_size), 128'(2));
    check("wr_busy_ic_ready", 128'(ic_req_ready), 128'(0));
    tick();
    mem_write_done = 1'b1;
    tick();
    mem_write_done = 1'b0;
    check("wr_done", 128'(dc_wr_done), 128'(1));
    check("wr_req_dropped", 128'(mem_wr_req_valid), 128'(0));
    check("wr_then_ic_ready", 128'(ic_req_ready), 128'(1));
    tick();
    ic_req_valid = 1'b0;
    check("wr_done_pulse", 128'(dc_wr_done), 128'(0));
    check("ic_after_wr_addr", 128'(mem_req_address), 128'(20'h02000));
    check("ic_after_wr_instr", 128'(mem_req_is_instr), 128'(1));
    mem_data_valid = 1'b1; mem_data_is_instr = 1'b1; mem_data = line_77;
    tick();
    mem_data_valid = 1'b0; mem_data_is_instr = 1'b0;
    check("ic_after_wr_data", ic_data, line_77);

    // 4. starvation guard: dc x4, ic, then dc again
    dc_req_valid = 1'b1; dc_req_we = 1'b0; dc_addr = 20'h03300; dc_size = 2'd1;
    ic_req_valid = 1'b1; ic_addr = 20'h04400;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("starve_dc_ready_%0d", i), 128'(dc_req_ready), 128'(i != 4));
      check($sformatf("starve_ic_ready_%0d", i), 128'(ic_req_ready), 128'(i == 4));
      tick();
      check($sformatf("starve_is_instr_%0d", i), 128'(mem_req_is_instr), 128'(i == 4));
      mem_data_valid = 1'b1; mem_data_is_instr = (i == 4); mem_data = line_55;
      tick();
      mem_data_valid = 1'b0; mem_data_is_instr = 1'b0;
    end
    dc_req_valid = 1'b0;
    ic_req_valid = 1'b0;
    check("starve_no_err", 128'(err), 128'(0));

    // 5. bad tag during RD_D, then stray write_done in IDLE
    tick();
    dc_req_valid = 1'b1; dc_addr = 20'h03000;
    tick();
    dc_req_valid = 1'b0;
    mem_data_valid = 1'b1; mem_data_is_instr = 1'b1; mem_data = line_ab;
    tick();
    mem_data_valid = 1'b0; mem_data_is_instr = 1'b0;
    check("badtag_dc_valid", 128'(dc_data_valid), 128'(1));
    check("badtag_dc_data", dc_data, line_ab);
    check("badtag_ic_valid", 128'(ic_data_valid), 128'(0));
    check("badtag_err", 128'(err), 128'(1));
    tick();
    mem_write_done = 1'b1;
    tick();
    mem_write_done = 1'b0;
    check("idle_done_no_pulse", 128'(dc_wr_done), 128'(0));
    tick(); tick();
    check("err_sticky", 128'(err), 128'(1));

    // 6. reset mid RD_D, then a late response
    dc_req_valid = 1'b1; dc_addr = 20'h04000;
    tick();
    dc_req_valid = 1'b0;
    check("mid_rd_req", 128'(mem_rd_req_valid), 128'(1));
    rst = 1'b0;
    #1;
    check("mid_rst_dc_ready", 128'(dc_req_ready), 128'(0));
    tick(); tick();
    check("mid_rst_err", 128'(err), 128'(0));
    check("mid_rst_rd_req", 128'(mem_rd_req_valid), 128'(0));
    check("mid_rst_addr", 128'(mem_req_address), 128'(0));
    check("mid_rst_dc_data", dc_data, 128'(0));
    rst = 1'b1;
    mem_data_valid = 1'b1; mem_data_is_instr = 1'b0; mem_data = line_55;
    tick();
    mem_data_valid = 1'b0;
    check("late_resp_no_valid", 128'(dc_data_valid), 128'(0));
    check("late_resp_err", 128'(err), 128'(1));
    ic_req_valid = 1'b1; ic_addr = 20'h05000;
    #1;
    check("recover_ic_ready", 128'(ic_req_ready), 128'(1));
    tick();
    ic_req_valid = 1'b0;
    check("recover_addr", 128'(mem_req_address), 128'(20'h05000));
    mem_data_valid = 1'b1; mem_data_is_instr = 1'b1; mem_data = line_77;
    tick();
    mem_data_valid = 1'b0; mem_data_is_instr = 1'b0;
    check("recover_ic_valid", 128'(ic_data_valid), 128'(1));
    check("recover_ic_data", ic_data, line_77);
    check("recover_err_sticky", 128'(err), 128'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
